// File: rtl/button_counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// button_counter_ctrl_pkg
//   Shared definitions for the pushbutton counter controller.
//   - 2-bit debounce FSM state encoding (RELEASED/PRESS_CHK/PRESSED/RELEASE_CHK)
//   - Button index constants into the 4-bit button vector
//   No ports (package).
// -----------------------------------------------------------------------------
package button_counter_ctrl_pkg;

   localparam logic [1:0] RELEASED    = 2'd0;
   localparam logic [1:0] PRESS_CHK   = 2'd1;
   localparam logic [1:0] PRESSED     = 2'd2;
   localparam logic [1:0] RELEASE_CHK = 2'd3;

   typedef enum logic [1:0] {
      ST_RELEASED    = RELEASED,
      ST_PRESS_CHK   = PRESS_CHK,
      ST_PRESSED     = PRESSED,
      ST_RELEASE_CHK = RELEASE_CHK
   } btn_state_e;

   localparam int NUM_BTN = 4;
   localparam int BTN_INC = 0;
   localparam int BTN_DEC = 1;
   localparam int BTN_CLR = 2;
   localparam int BTN_INV = 3;

endpackage

// File: rtl/button_counter_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// button_counter_ctrl_btn_debounce
//   One pushbutton: 2-flop synchroniser, polarity normalisation, 4-state
//   debounce FSM with saturating timer, registered one-cycle press pulse.
//   Optional auto-repeat (macro AUTOREPEAT_EN) for buttons with REPEAT_ALLOWED.
// Ports:
//   clk_i    in  1  system clock
//   rst_n_i  in  1  asynchronous active-low reset
//   btn_i    in  1  raw asynchronous button pin
//   press_o  out 1  one-cycle pulse per accepted press (or repeat), registered
// -----------------------------------------------------------------------------
module button_counter_ctrl_btn_debounce
   import button_counter_ctrl_pkg::*;
#(
   parameter int DB_CYCLES   = 120000,
   parameter int BTN_ACT_LOW = 1
`ifdef AUTOREPEAT_EN
   ,
   parameter int RPT_DELAY      = 6000000,
   parameter int RPT_PERIOD     = 1200000,
   parameter bit REPEAT_ALLOWED = 1'b0
`endif
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic btn_i,
   output logic press_o
);

   localparam int   TW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic IDLE_LVL = (BTN_ACT_LOW != 0);
   localparam logic [TW-1:0] T_LAST = TW'(DB_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          p;
   btn_state_e    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d, timer_inc;
   logic          fsm_pulse;
   logic          press_q, press_d;

   // Pressed = synchronised level differs from the idle (released) level.
   assign p         = sync_q[1] ^ IDLE_LVL;
   assign timer_inc = (&timer_q) ? timer_q : timer_q + TW'(1);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q  <= {2{IDLE_LVL}};
         state_q <= ST_RELEASED;
         timer_q <= '0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_i};
         state_q <= state_d;
         timer_q <= timer_d;
         press_q <= press_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      fsm_pulse = 1'b0;
      case (state_q)
         ST_RELEASED: begin
            if (p) begin
               state_d = ST_PRESS_CHK;
               timer_d = '0;
            end
         end
         ST_PRESS_CHK: begin
            if (!p) begin
               state_d = ST_RELEASED;
            end else if (timer_q == T_LAST) begin
               state_d   = ST_PRESSED;
               fsm_pulse = 1'b1;
            end else begin
               timer_d = timer_inc;
            end
         end
         ST_PRESSED: begin
            if (!p) begin
               state_d = ST_RELEASE_CHK;
               timer_d = '0;
            end
         end
         ST_RELEASE_CHK: begin
            if (p) begin
               state_d = ST_PRESSED;
            end else if (timer_q == T_LAST) begin
               state_d = ST_RELEASED;
            end else begin
               timer_d = timer_inc;
            end
         end
         default: state_d = ST_RELEASED;
      endcase
   end

`ifdef AUTOREPEAT_EN
   localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
   localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

   logic [RW-1:0] rpt_q, rpt_d;
   logic          phase_q, phase_d;   // 0: waiting initial delay, 1: periodic
   logic          rpt_pulse;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rpt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         rpt_q   <= rpt_d;
         phase_q <= phase_d;
      end
   end

   // Repeat timer only runs while staying in PRESSED; anything else clears it.
   always_comb begin
      rpt_d     = '0;
      phase_d   = 1'b0;
      rpt_pulse = 1'b0;
      if (REPEAT_ALLOWED && state_q == ST_PRESSED && p) begin
         phase_d = phase_q;
         if (rpt_q == (phase_q ? RW'(RPT_PERIOD - 1) : RW'(RPT_DELAY - 1))) begin
            rpt_pulse = 1'b1;
            phase_d   = 1'b1;
         end else begin
            rpt_d = rpt_q + RW'(1);
         end
      end
   end

   assign press_d = fsm_pulse | rpt_pulse;
`else
   assign press_d = fsm_pulse;
`endif

   assign press_o = press_q;

endmodule

// File: rtl/button_counter_ctrl.sv
// -----------------------------------------------------------------------------
// button_counter_ctrl
//   Debounces 4 board pushbuttons and applies press events to an 8-bit count
//   shown on the LEDs (optionally inverted). Macro AUTOREPEAT_EN enables
//   auto-repeat on the inc/dec buttons.
// Ports:
//   clk_i        in  1  system clock (12 MHz)
//   rst_n_i      in  1  asynchronous active-low reset
//   btn_i        in  4  raw buttons: [0]=inc [1]=dec [2]=clear [3]=invert
//   btn_press_o  out 4  one-cycle press pulses, registered
//   led_o        out 8  count, XOR 8'hFF when invert flag set, registered
// -----------------------------------------------------------------------------
module button_counter_ctrl
   import button_counter_ctrl_pkg::*;
#(
   parameter int DB_CYCLES   = 120000,
   parameter int BTN_ACT_LOW = 1,
   parameter int RPT_DELAY   = 6000000,
   parameter int RPT_PERIOD  = 1200000
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [NUM_BTN-1:0] btn_i,
   output logic [NUM_BTN-1:0] btn_press_o,
   output logic [7:0]         led_o
);

   if (DB_CYCLES < 2 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_cfg
      $error("button_counter_ctrl: DB_CYCLES must be >= 2 and repeat intervals >= 1");
   end

   logic [NUM_BTN-1:0] press;
   logic [7:0]         count_q, count_d;
   logic               inv_q, inv_d;
   logic [7:0]         led_q, led_d;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      button_counter_ctrl_btn_debounce #(
         .DB_CYCLES      (DB_CYCLES),
         .BTN_ACT_LOW    (BTN_ACT_LOW)
`ifdef AUTOREPEAT_EN
         ,
         .RPT_DELAY      (RPT_DELAY),
         .RPT_PERIOD     (RPT_PERIOD),
         .REPEAT_ALLOWED ((gi == BTN_INC) || (gi == BTN_DEC))
`endif
      ) u_db (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .btn_i   (btn_i[gi]),
         .press_o (press[gi])
      );
   end

   // Clear wins; simultaneous inc and dec cancel.
   always_comb begin
      count_d = count_q;
      inv_d   = inv_q ^ press[BTN_INV];
      if (press[BTN_CLR]) begin
         count_d = 8'h00;
      end else if (press[BTN_INC] && !press[BTN_DEC]) begin
         count_d = count_q + 8'd1;
      end else if (press[BTN_DEC] && !press[BTN_INC]) begin
         count_d = count_q - 8'd1;
      end
      // LED follows the new count in the same cycle it is updated.
      led_d = count_d ^ {8{inv_d}};
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_q <= 8'h00;
         inv_q   <= 1'b0;
         led_q   <= 8'h00;
      end else begin
         count_q <= count_d;
         inv_q   <= inv_d;
         led_q   <= led_d;
      end
   end

   assign btn_press_o = press;
   assign led_o       = led_q;

endmodule

// File: tb/tb_button_counter_ctrl.sv
module tb_button_counter_ctrl;

   localparam int DB = 4;
   localparam int LAT = DB + 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] btn = 4'hF;
   logic [3:0] press;
   logic [7:0] led;

   button_counter_ctrl #(
      .DB_CYCLES   (DB),
      .BTN_ACT_LOW (1),
      .RPT_DELAY   (20),
      .RPT_PERIOD  (8)
   ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .btn_i       (btn),
      .btn_press_o (press),
      .led_o       (led)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0] mask;
      int         cyc;
      logic [7:0] led;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] m_cnt = 8'h00;
   logic       m_inv = 1'b0;
   logic       led_pend = 1'b0;
   logic [7:0] led_exp = 8'h00;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference behaviour of one pulse vector on count/invert; returns LED.
   function automatic logic [7:0] model_apply(logic [3:0] m);
      if (m[2])                 m_cnt = 8'h00;
      else if (m[0] && !m[1])   m_cnt = m_cnt + 8'd1;
      else if (m[1] && !m[0])   m_cnt = m_cnt - 8'd1;
      if (m[3]) m_inv = ~m_inv;
      return m_cnt ^ {8{m_inv}};
   endfunction

   function automatic logic [7:0] model_led();
      return m_cnt ^ {8{m_inv}};
   endfunction

   // Monitor: any pulse pops the scoreboard; LED checked the following cycle.
   always @(negedge clk) begin
      if (led_pend) begin
         chk("led_after_pulse", 32'(led), 32'(led_exp));
         led_pend <= 1'b0;
      end
      if (press !== 4'b0000) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", 32'(press), 32'h0);
         end else begin
            mon_e = sb.pop_front();
            chk("pulse_mask", 32'(press), 32'(mon_e.mask));
            chk("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
            $display("pulse cyc=%0d mask=%b led_exp=%h", cyc, press, mon_e.led);
            led_exp  <= mon_e.led;
            led_pend <= 1'b1;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] mask, input int at);
      exp_t e;
      e.mask = mask;
      e.cyc  = at;
      e.led  = model_apply(mask);
      sb.push_back(e);
   endtask

   // Press buttons in mask together, hold, release and let release debounce.
   task automatic press_btn(input logic [3:0] mask, input int hold);
      push(mask, cyc + LAT);
      btn = ~mask;
      idle(hold);
      btn = 4'hF;
      idle(12);
   endtask

   initial begin
      int e0;
      // 1. reset and idle
      idle(3);
      chk("reset_led", 32'(led), 32'h00);
      chk("reset_press", 32'(press), 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         idle(1);
         chk("idle_led", 32'(led), 32'h00);
         chk("idle_press", 32'(press), 32'h0);
      end

      // 2. single inc press, held 20 cycles
      press_btn(4'b0001, 20);
      chk("s2_led", 32'(led), 32'h01);

      // 3. bounce shorter than debounce window
      for (int i = 0; i < 5; i++) begin
         btn = 4'hE; idle(3);
         btn = 4'hF; idle(1);
      end
      idle(12);
      chk("s3_led", 32'(led), 32'(model_led()));

      // 4. dec wrap down, 256 inc wrap up
      press_btn(4'b0100, 10);
      press_btn(4'b0010, 10);
      chk("s4_dec_wrap", 32'(led), 32'hFF);
      press_btn(4'b0100, 10);
      for (int i = 0; i < 256; i++) press_btn(4'b0001, 10);
      chk("s4_inc_wrap", 32'(led), 32'h00);

      // 5. priorities and invert
      for (int i = 0; i < 16; i++) press_btn(4'b0001, 10);
      chk("s5_count10", 32'(led), 32'h10);
      press_btn(4'b0101, 10);
      chk("s5_inc_clr", 32'(led), 32'h00);
      for (int i = 0; i < 3; i++) press_btn(4'b0001, 10);
      press_btn(4'b0011, 10);
      chk("s5_inc_dec", 32'(led), 32'h03);
      for (int i = 0; i < 12; i++) press_btn(4'b0001, 10);
      press_btn(4'b1000, 10);
      chk("s5_invert", 32'(led), 32'hF0);

      // 6. long hold of inc (repeats only with AUTOREPEAT_EN)
      e0 = cyc;
      push(4'b0001, e0 + LAT);
`ifdef AUTOREPEAT_EN
      push(4'b0001, e0 + 27);
      push(4'b0001, e0 + 35);
      push(4'b0001, e0 + 43);
      push(4'b0001, e0 + 51);
      push(4'b0001, e0 + 59);
`endif
      btn = 4'hE;
      idle(60);
      btn = 4'hF;
      idle(12);
      chk("s6_led", 32'(led), 32'(model_led()));

      // 7. reset asserted mid-debounce: no pulse afterwards
      btn = 4'hE;
      idle(4);
      rst_n = 1'b0;
      btn = 4'hF;
      idle(2);
      chk("s7_reset_led", 32'(led), 32'h00);
      m_cnt = 8'h00;
      m_inv = 1'b0;
      rst_n = 1'b1;
      idle(15);
      chk("s7_led", 32'(led), 32'h00);

      // 8. button held through reset release: one pulse after debounce
      rst_n = 1'b0;
      btn = 4'hE;
      idle(2);
      rst_n = 1'b1;
      push(4'b0001, cyc + LAT);
      idle(10);
      btn = 4'hF;
      idle(12);
      chk("s8_led", 32'(led), 32'h01);

      chk("sb_drained", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
